// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

   localparam int FQ_PC_W    = 32;
   localparam int FQ_INSTR_W = 32;

   // addi x0,x0,0 -- what decode sees when nothing is queued
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   // Also used by the PC stage as its reset vector
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;

   typedef struct packed {
      logic [FQ_PC_W-1:0]    pc;
      logic [FQ_INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetchq_ram.sv
// Fetch queue storage: DEPTH entries, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module fetchq_ram
   import fetch_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = fetch_entry_t
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  entry_t                   wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output entry_t                   rdata
);

   entry_t mem [DEPTH];

   // Write the addressed slot on the rising edge
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between PC/IMEM stage and decode.
// Optional zero-latency empty-queue bypass: define FETCHQ_BYPASS_EN.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [PC_W-1:0]          in_pc,
   input  logic [INSTR_W-1:0]       in_instr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PC_W-1:0]          out_pc,
   output logic [INSTR_W-1:0]       out_instr,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          mem_valid, byp, push, pop, wr_en, rd_en;
   entry_t        in_ent, rd_ent, head;

   assign in_ent = '{pc: in_pc, instr: in_instr};

   fetchq_ram #(.DEPTH(DEPTH), .entry_t(entry_t)) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr_q),
      .wdata (in_ent),
      .raddr (rd_ptr_q),
      .rdata (rd_ent)
   );

   // rst gates the handshakes so nothing completes while reset is held
   assign in_ready  = rst && (count_q < CW'(DEPTH)) && !flush;
   assign mem_valid = rst && (count_q != '0) && !flush;

`ifdef FETCHQ_BYPASS_EN
   // Empty queue forwards the incoming entry straight to decode
   assign byp = rst && (count_q == '0) && in_valid && !flush;
`else
   assign byp = 1'b0;
`endif

   assign out_valid = mem_valid || byp;
   assign head      = mem_valid ? rd_ent : in_ent;
   assign out_pc    = out_valid ? head.pc    : '0;
   assign out_instr = out_valid ? head.instr : INSTR_W'(NOP_INSTR);
   assign count     = count_q;

   assign push  = in_valid && in_ready;
   assign pop   = out_valid && out_ready;
   // A bypassed entry that decode takes immediately never touches storage
   assign wr_en = push && !(byp && out_ready);
   assign rd_en = pop && mem_valid;

   // Next pointer/count state; flush overrides any handshake
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
         if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer/count registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
   logic        in_ready, out_valid;
   logic [31:0] in_pc = '0, in_instr = '0, out_pc, out_instr;
   logic [2:0]  count;

   int n_asrt = 0;
   int n_fail = 0;

   fetch_queue #(.DEPTH(4), .PC_W(32), .INSTR_W(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
      .flush(flush), .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      n_asrt++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
      n_asrt++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b exp 0", in_ready); end
      n_asrt++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d exp 0", count); end
      n_asrt++; if (out_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL rst_nop: got %h exp 00000013", out_instr); end
      n_asrt++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h exp 0", out_pc); end
      tick(); tick();
      rst = 1'b1;
      #1;
      n_asrt++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready: got %b exp 1", in_ready); end
   endtask

   task automatic test_single();
      in_valid = 1'b1; in_pc = 32'h0; in_instr = 32'h4356_AE86;
      tick();
      in_valid = 1'b0;
      #1;
      n_asrt++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b exp 1", out_valid); end
      n_asrt++; if (out_instr !== 32'h4356_AE86) begin n_fail++; $display("FAIL single_instr: got %h exp 4356ae86", out_instr); end
      n_asrt++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d exp 1", count); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_asrt++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h4356_AE86) begin
            n_fail++; $display("FAIL stall_hold%0d: got v=%b pc=%h instr=%h exp v=1 pc=0 instr=4356ae86", i, out_valid, out_pc, out_instr);
         end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      #1;
      n_asrt++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL single_drain: got v=%b cnt=%0d exp v=0 cnt=0", out_valid, count); end
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_pc = 32'(4 * i); in_instr = 32'h100 + 32'(i);
         tick();
      end
      in_valid = 1'b0;
      #1;
      n_asrt++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d exp 4", count); end
      n_asrt++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b exp 0", in_ready); end
      in_valid = 1'b1; in_pc = 32'h10; in_instr = 32'h104;
      tick();
      n_asrt++; if (count !== 3'd4 || out_pc !== 32'h0) begin n_fail++; $display("FAIL full_ignore: got cnt=%0d pc=%h exp cnt=4 pc=0", count, out_pc); end
      // pop while full with a push pending: only the pop may happen
      out_ready = 1'b1;
      #1;
      n_asrt++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_ready: got %b exp 0", in_ready); end
      tick();
      in_valid = 1'b0;
      #1;
      n_asrt++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_pop_count: got %0d exp 3", count); end
      for (int i = 1; i < 4; i++) begin
         n_asrt++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== 32'h100 + 32'(i)) begin
            n_fail++; $display("FAIL drain%0d: got v=%b pc=%h instr=%h exp pc=%h", i, out_valid, out_pc, out_instr, 4 * i);
         end
         tick();
      end
      n_asrt++; if (out_valid !== 1'b0 || out_instr !== 32'h0000_0013 || count !== 3'd0) begin
         n_fail++; $display("FAIL drain_empty: got v=%b instr=%h cnt=%0d exp v=0 instr=00000013 cnt=0", out_valid, out_instr, count);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int k = 0; k <= 10; k++) begin
         in_pc = 32'(4 * k); in_instr = 32'hA5A5_0000 ^ 32'(k);
         #1;
         if (k > 0) begin
            n_asrt++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * (k - 1)) || out_instr !== (32'hA5A5_0000 ^ 32'(k - 1)) || count !== 3'd1) begin
               n_fail++; $display("FAIL stream%0d: got v=%b pc=%h instr=%h cnt=%0d exp pc=%h cnt=1", k, out_valid, out_pc, out_instr, count, 4 * (k - 1));
            end
         end
         tick();
      end
      in_valid = 1'b0;
      #1;
      n_asrt++; if (out_pc !== 32'h28 || count !== 3'd1) begin n_fail++; $display("FAIL stream_last: got pc=%h cnt=%0d exp pc=28 cnt=1", out_pc, count); end
      tick();
      n_asrt++; if (count !== 3'd0) begin n_fail++; $display("FAIL stream_empty: got %0d exp 0", count); end
      out_ready = 1'b0;
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_pc = 32'h40 + 32'(4 * i); in_instr = 32'h200 + 32'(i);
         tick();
      end
      in_valid = 1'b0;
      #1;
      n_asrt++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_fill: got %0d exp 3", count); end
      flush = 1'b1; in_valid = 1'b1; in_pc = 32'h50; out_ready = 1'b1;
      #1;
      n_asrt++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_cycle: got rdy=%b v=%b exp 0 0", in_ready, out_valid); end
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      n_asrt++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after: got cnt=%0d v=%b exp 0 0", count, out_valid); end
      in_valid = 1'b1; in_pc = 32'h80; in_instr = 32'h300;
      #1;
      n_asrt++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_repush_rdy: got %b exp 1", in_ready); end
      tick();
      in_valid = 1'b0;
      #1;
      n_asrt++; if (out_valid !== 1'b1 || out_pc !== 32'h80 || count !== 3'd1) begin
         n_fail++; $display("FAIL flush_repush: got v=%b pc=%h cnt=%0d exp v=1 pc=80 cnt=1", out_valid, out_pc, count);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_pc = 32'h60 + 32'(4 * i); in_instr = 32'h400 + 32'(i);
         tick();
      end
      in_valid = 1'b0;
      #1;
      n_asrt++; if (count !== 3'd2) begin n_fail++; $display("FAIL mid_fill: got %0d exp 2", count); end
      #2;
      rst = 1'b0; in_valid = 1'b1;
      #1;
      n_asrt++; if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset: got v=%b cnt=%0d rdy=%b exp 0 0 0", out_valid, count, in_ready);
      end
      tick();
      n_asrt++; if (in_ready !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL mid_hold: got rdy=%b cnt=%0d exp 0 0", in_ready, count); end
      rst = 1'b1; in_valid = 1'b0;
      #1;
      n_asrt++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_release: got rdy=%b v=%b exp 1 0", in_ready, out_valid); end
   endtask

   task automatic test_bypass();
      in_valid = 1'b1; in_pc = 32'h14; in_instr = 32'h1234_3123; out_ready = 1'b1;
      #1;
`ifdef FETCHQ_BYPASS_EN
      n_asrt++; if (out_valid !== 1'b1 || out_pc !== 32'h14 || out_instr !== 32'h1234_3123) begin
         n_fail++; $display("FAIL byp_same: got v=%b pc=%h instr=%h exp v=1 pc=14 instr=12343123", out_valid, out_pc, out_instr);
      end
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      n_asrt++; if (count !== 3'd0) begin n_fail++; $display("FAIL byp_count: got %0d exp 0", count); end
`else
      n_asrt++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL nobyp_same: got %b exp 0", out_valid); end
      tick();
      in_valid = 1'b0;
      #1;
      n_asrt++; if (out_valid !== 1'b1 || out_instr !== 32'h1234_3123 || count !== 3'd1) begin
         n_fail++; $display("FAIL nobyp_next: got v=%b instr=%h cnt=%0d exp v=1 instr=12343123 cnt=1", out_valid, out_instr, count);
      end
      tick();
      out_ready = 1'b0;
      #1;
      n_asrt++; if (count !== 3'd0) begin n_fail++; $display("FAIL nobyp_drain: got %0d exp 0", count); end
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_bypass();
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
